// File: rtl/tankb_video_pkg.sv
// Shared constants and types for the playfield video path: default raster
// timing, slot phase numbers within an 8-pixel tile period, CPU arbiter states.
package tankb_video_pkg;

  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_V_ACTIVE = 224;

  localparam logic [2:0] PH_TILE      = 3'd0;
  localparam logic [2:0] PH_TLATCH    = 3'd1;
  localparam logic [2:0] PH_GLATCH    = 3'd3;
  localparam logic [2:0] PH_CPU_FIRST = 3'd4;
  localparam logic [2:0] PH_CPU_LAST  = 3'd6;
  localparam logic [2:0] PH_LOAD      = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} cpu_state_t;

endpackage

// File: rtl/video_counter.sv
// Horizontal/vertical pixel counter chain with blank decode. Also exports the
// position the counters will hold after this clk, used by registered strobes.
module video_counter
  import tankb_video_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_ce,
  output logic [8:0] o_hcnt,
  output logic [8:0] o_vcnt,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic [2:0] o_nxt_phase,
  output logic [4:0] o_nxt_fetch_col,
  output logic [4:0] o_nxt_row,
  output logic       o_nxt_active
);

  localparam logic [8:0] LP_H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] LP_V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] LP_H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] LP_V_ACT  = 9'(V_ACTIVE);

  logic [8:0] r_hcnt, r_vcnt;
  logic [8:0] w_h_nxt, w_v_nxt;

  always_comb begin
    w_h_nxt = r_hcnt;
    w_v_nxt = r_vcnt;
    if (i_pix_ce) begin
      if (r_hcnt == LP_H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_vcnt == LP_V_LAST) ? '0 : r_vcnt + 9'd1;
      end else begin
        w_h_nxt = r_hcnt + 9'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_h_nxt;
      r_vcnt <= w_v_nxt;
    end
  end

  assign o_hcnt          = r_hcnt;
  assign o_vcnt          = r_vcnt;
  assign o_hblank        = (r_hcnt >= LP_H_ACT);
  assign o_vblank        = (r_vcnt >= LP_V_ACT);
  assign o_nxt_phase     = w_h_nxt[2:0];
  // Fetch runs one tile ahead of the pixels being shifted out; column 31 wraps.
  assign o_nxt_fetch_col = w_h_nxt[7:3] + 5'd1;
  assign o_nxt_row       = w_v_nxt[7:3];
  assign o_nxt_active    = (w_h_nxt < LP_H_ACT) && (w_v_nxt < LP_V_ACT);

endmodule

// File: rtl/vram_fetch_sequencer.sv
// Playfield slot scheduler: video fetch / CPU slot arbitration on the shared
// tile VRAM and latch/load strobes. Optional FLIP_SCREEN_EN adds a flip input.
module vram_fetch_sequencer
  import tankb_video_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic       clk,
  input  logic       res,
  input  logic       pix_ce,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
`ifdef FLIP_SCREEN_EN
  input  logic       flip,
`endif
  output logic       cpu_ack,
  output logic [9:0] vram_addr,
  output logic       vram_we,
  output logic       tile_latch,
  output logic       gfx_latch,
  output logic       sh_load_n,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hblank,
  output logic       vblank
);

  logic [2:0] w_phase;
  logic [4:0] w_col, w_row, w_fcol, w_frow;
  logic       w_active, w_cpu_slot, w_fetch;
  logic [9:0] w_addr_nxt;
  logic       w_we_nxt;
  cpu_state_t r_state, w_state_nxt;
  logic [9:0] r_vram_addr;
  logic       r_vram_we, r_tile_latch, r_gfx_latch, r_sh_load_n;

  video_counter #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .V_ACTIVE(V_ACTIVE)
  ) u_cnt (
    .i_clk          (clk),
    .i_rst          (res),
    .i_pix_ce       (pix_ce),
    .o_hcnt         (hcnt),
    .o_vcnt         (vcnt),
    .o_hblank       (hblank),
    .o_vblank       (vblank),
    .o_nxt_phase    (w_phase),
    .o_nxt_fetch_col(w_col),
    .o_nxt_row      (w_row),
    .o_nxt_active   (w_active)
  );

`ifdef FLIP_SCREEN_EN
  assign w_frow = flip ? ~w_row : w_row;
  assign w_fcol = flip ? ~w_col : w_col;
`else
  assign w_frow = w_row;
  assign w_fcol = w_col;
`endif

  // Slots are judged on the phase being entered so every register lines up with it.
  assign w_cpu_slot = !w_active || ((w_phase >= PH_CPU_FIRST) && (w_phase <= PH_CPU_LAST));
  assign w_fetch    = w_active && (w_phase == PH_TILE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (pix_ce && cpu_req && w_cpu_slot) w_state_nxt = ACCESS;
      ACCESS:  if (pix_ce) w_state_nxt = ACK;
      ACK:     if (!cpu_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_addr_nxt = cpu_addr;
    w_we_nxt   = 1'b0;
    if (w_state_nxt == ACCESS) begin
      w_we_nxt = cpu_we;
    end else if (w_fetch) begin
      w_addr_nxt = {w_frow, w_fcol};
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= IDLE;
      r_vram_addr  <= '0;
      r_vram_we    <= 1'b0;
      r_tile_latch <= 1'b0;
      r_gfx_latch  <= 1'b0;
      r_sh_load_n  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_vram_addr  <= w_addr_nxt;
      r_vram_we    <= w_we_nxt;
      r_tile_latch <= pix_ce && w_active && (w_phase == PH_TLATCH);
      r_gfx_latch  <= pix_ce && w_active && (w_phase == PH_GLATCH);
      r_sh_load_n  <= !(pix_ce && w_active && (w_phase == PH_LOAD));
    end
  end

  assign cpu_ack    = (r_state == ACK);
  assign vram_addr  = r_vram_addr;
  assign vram_we    = r_vram_we;
  assign tile_latch = r_tile_latch;
  assign gfx_latch  = r_gfx_latch;
  assign sh_load_n  = r_sh_load_n;

endmodule

// File: doc/vram_fetch_sequencer.md
# vram_fetch_sequencer

Slot scheduler for the playfield video path. Generates the horizontal and vertical pixel counters. Divides every 8-pixel tile period into fixed video-fetch and CPU slots, and arbitrates CPU access to the shared 1 KB tile VRAM. It drives the strobes that sequence the downstream tile-code latch (8-bit register), graphics latch and 8-bit parallel-load shift register.

## Interface
- H_TOTAL, 384: pixels per line
- H_ACTIVE, 256: visible pixels per line
- V_TOTAL, 264: lines per frame
- V_ACTIVE, 224: visible lines
- clk  in  1  master clock; all state changes on rising edge
- res  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel clock enable; sequencer advances only when high
- cpu_req  in  1  CPU access request; four-phase with cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  10  CPU VRAM address
- cpu_ack  out  1  access done; high until cpu_req low
- vram_addr  out  10  shared VRAM address
- vram_we  out  1  VRAM write strobe
- tile_latch  out  1  one-clk strobe: capture tile code
- gfx_latch  out  1  one-clk strobe: capture graphics byte
- sh_load_n  out  1  active-low parallel load for pixel shift register
- hcnt  out  9  horizontal count
- vcnt  out  9  vertical count
- hblank, vblank  out  1  blanking flags

## Operation
- Counters: hcnt 0..H_TOTAL-1, then wraps to 0 and increments vcnt. vcnt 0..V_TOTAL-1, then wraps. Both step on pix_ce only.
- hblank = hcnt >= H_ACTIVE; vblank = vcnt >= V_ACTIVE. Both are decoded from the registered counters.
- phase = hcnt[2:0]. Slots during active video (hblank=0 and vblank=0):
  - phase 0: video fetch; vram_addr = {vcnt[7:3], (hcnt[7:3]+1) mod 32}. Column 31 wraps to column 0 of the same row.
  - phase 1: tile_latch pulse.
  - phase 3: gfx_latch pulse.
  - phases 4-6: CPU slot.
  - phase 7: sh_load_n low for this pix_ce period.
- During blanking, every phase is a CPU slot. No latch or load strobes are issued.
- CPU FSM:
  - IDLE -> ACCESS: on a pix_ce cycle in a CPU slot with cpu_req=1.
  - ACCESS: lasts one pix_ce period. vram_addr = cpu_addr; vram_we = cpu_we.
  - ACCESS -> ACK: at the next pix_ce.
  - ACK: cpu_ack=1. ACK -> IDLE when cpu_req=0.
- ACCESS started in phase 6 completes even if the next phase is a video slot. The video fetch is never delayed; this is guaranteed by the slot layout (phase 7 does not use VRAM).
- A request arriving during ACK is not serviced until cpu_req has been seen low.
- Outside ACCESS and video fetch, vram_addr holds cpu_addr and vram_we=0.

## Timing
- Reset values: hcnt=0, vcnt=0, hblank=0, vblank=0, cpu_ack=0, vram_we=0, tile_latch=0, gfx_latch=0, sh_load_n=1, vram_addr=0, FSM=IDLE.
- res asserted mid-access: vram_we drops asynchronously and the access is abandoned; no ack is issued.
- Strobes are registered and last exactly one clk, coincident with the pix_ce cycle of their phase.
- CPU latency, measured in pix_ce periods from request to cpu_ack: best case 2; worst case 6 during active video (request arrives just after phase 6).
- When pix_ce=1 every clk, all rules hold with clk == pixel.

## Configuration
- FLIP_SCREEN_EN:
  - Defined: adds input port flip (1 bit). When flip=1, the video fetch address uses ~vcnt[7:3] and ~((hcnt[7:3]+1) mod 32). CPU addresses are unaffected.
  - Undefined: no flip port; normal orientation only.

## Structure
- Package tankb_video_pkg holds:
  - slot phase constants: PH_TILE=0, PH_TLATCH=1, PH_GLATCH=3, PH_CPU_FIRST=4, PH_CPU_LAST=6, PH_LOAD=7;
  - the CPU FSM state typedef (IDLE, ACCESS, ACK);
  - default timing constants.
- Sub-module video_counter: the hcnt/vcnt chain with wrap and blank decode. The arbiter and strobe logic live in the top module.

## Test plan
- Reset released, pix_ce=1 every clk, 384 clks -> hcnt wraps 383->0, vcnt 0->1. hblank rises at hcnt=256.
- Active video, hcnt=8, vcnt=16 -> at phase 0 vram_addr=0x042. tile_latch at hcnt=9; gfx_latch at hcnt=11; sh_load_n low at hcnt=15.
- hcnt=248 (column 31) -> fetch address column 0 of the same row, i.e. {vcnt[7:3],5'd0}.
- cpu_req=1, cpu_we=1, cpu_addr=0x155 asserted at hcnt=7 (phase 7) -> ACCESS at phase 4 with vram_we=1 and vram_addr=0x155. cpu_ack high one pix_ce later; it stays high until req drops, then falls the next clk.
- CPU request during vblank at phase 0 -> serviced in that slot; no tile_latch or sh_load_n strobes throughout the frame's blank lines.
- res pulsed during ACCESS with vram_we=1 -> vram_we=0 immediately; cpu_ack never rises; counters read 0.
